m_branch_predictor: RTL and testbench
=====================================

M_BRANCH_PREDICTOR -- requirements
Module: m_branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 10, log2 of table entries (ENTRIES = 2^IDX_W).
REQ-002 SHALL have parameter TAG_W, default 8, number of PC tag bits stored per entry.
REQ-003 SHALL have parameter CTR_W, default 2, width of the saturating direction counter (range 1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ce  input  1  clock enable; low freezes all state and outputs.
REQ-007 SHALL have port ready  output  1  high when the table is initialised and serving requests.
REQ-008 SHALL have port req_valid  input  1  lookup request strobe.
REQ-009 SHALL have port req_pc  input  32  PC of the fetched instruction.
REQ-010 SHALL have port rsp_valid  output  1  lookup response valid, one cycle after the request.
REQ-011 SHALL have port rsp_taken  output  1  predict taken.
REQ-012 SHALL have port rsp_target  output  32  predicted target; 0 when rsp_taken is low.
REQ-013 SHALL have port upd_valid  input  1  resolved-branch update strobe.
REQ-014 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-015 SHALL have port upd_taken  input  1  actual outcome.
REQ-016 SHALL have port upd_target  input  32  actual target, meaningful when upd_taken is high.

Function
REQ-017 SHALL derive index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2] for both ports.
REQ-018 SHALL hold per entry: valid, tag, CTR_W-bit counter, 32-bit target.
REQ-019 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep index 0.
REQ-020 In INIT, SHALL clear valid of one entry per ce cycle at the sweep index, then increment it; after entry ENTRIES-1 is cleared, SHALL enter RUN on the next edge.
REQ-021 SHALL drive ready=1 only in RUN; INIT takes exactly ENTRIES ce-cycles.
REQ-022 In INIT, SHALL ignore req_valid (rsp_valid stays 0) and drop upd_valid.
REQ-023 In RUN, SHALL register a lookup with req_valid=1 at edge N and present rsp_valid=1 with the result during cycle N+1 (latency 1); rsp_valid=0 in cycles with no accepted request.
REQ-024 hit = entry valid and stored tag equals request tag; rsp_taken = hit AND counter MSB; rsp_target = stored target if rsp_taken, else 0.
REQ-025 Update, hit (valid, tag match): counter +1 if upd_taken, -1 if not, saturating at 2^CTR_W-1 and 0; target overwritten with upd_target only if upd_taken.
REQ-026 Update, miss with upd_taken=1: SHALL allocate (overwrite) the entry: valid=1, new tag, target=upd_target, counter=2^(CTR_W-1) (weakly taken).
REQ-027 Update, miss with upd_taken=0: SHALL leave the entry unchanged.
REQ-028 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents; update takes effect from the next cycle.
REQ-029 Updates SHALL apply in one cycle; back-to-back updates to the same entry every cycle SHALL each take effect in order, with no lost increments.
REQ-030 With ce=0: no sweep progress, no updates, no lookups accepted, outputs hold.
REQ-031 PC bits [1:0] SHALL be ignored.

Reset
REQ-032 On rst assertion, SHALL immediately drive ready=0, rsp_valid=0, rsp_taken=0, rsp_target=0, FSM=INIT, sweep index=0, regardless of clk.
REQ-033 rst asserted mid-INIT or mid-RUN SHALL restart the full sweep; all prior entries become invalid.
REQ-034 Tag, counter, and target storage need no reset; only valid bits are cleared (via the sweep).

Verification (IDX_W=4, TAG_W=8, CTR_W=2)
REQ-035 rst pulse, ce=1 -> ready=0 for exactly 16 cycles after deassertion, then 1; requests during INIT give rsp_valid=0.
REQ-036 upd pc=0x40 taken target=0x100; lookup pc=0x40 next cycle -> rsp_taken=1, rsp_target=0x100; lookup pc=0x440 (same index, other tag) -> rsp_taken=0, rsp_target=0.
REQ-037 From counter=2 at pc=0x40: two not-taken updates -> taken then not-taken predictions (counter 1, then 0); third not-taken keeps 0; three taken updates -> counter 3, further taken stays 3.
REQ-038 Same-cycle lookup and first allocating update at pc=0x80 -> response rsp_taken=0; repeated lookup one cycle later -> rsp_taken=1.
REQ-039 Populate entries, assert rst mid-RUN for 1 cycle -> sweep restarts; after ready returns, all lookups rsp_taken=0.
REQ-040 Hold ce=0 for 5 cycles during INIT -> ready asserts 5 cycles later than nominal; update with ce=0 has no effect.

Source files
------------

// File: rtl/m_branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with saturating direction counters and targets.
// After reset, an init sweep clears one valid bit per enabled cycle, then lookups and updates are served.
module m_branch_predictor #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8,
    parameter int CTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic        ready,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic        rsp_taken,
    output logic [31:0] rsp_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_sweep;
    logic               r_ready;
    logic               r_rsp_valid;
    logic               r_rsp_taken;
    logic [31:0]        r_rsp_target;

    logic               r_valid  [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_req_taken;
    logic               w_upd_hit;
    logic [CTR_W-1:0]   w_ctr_init;
    logic               w_unused_pc;

    assign w_req_idx  = req_pc[IDX_W+1:2];
    assign w_req_tag  = req_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_upd_idx  = upd_pc[IDX_W+1:2];
    assign w_upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ctr_init = CTR_W'(1) << (CTR_W - 1);
    assign w_unused_pc = ^{req_pc[31:IDX_W+TAG_W+2], req_pc[1:0],
                           upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

    always_comb begin
        w_req_taken = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag)
                      && r_ctr[w_req_idx][CTR_W-1];
        w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    end

    // Control and response registers; response reads the table before this edge's update lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_ready      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_taken  <= 1'b0;
            r_rsp_target <= '0;
        end else if (ce) begin
            case (r_state)
                ST_INIT: begin
                    r_sweep      <= r_sweep + 1'b1;
                    r_rsp_valid  <= 1'b0;
                    r_rsp_taken  <= 1'b0;
                    r_rsp_target <= '0;
                    if (r_sweep == '1) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rsp_valid  <= req_valid;
                    r_rsp_taken  <= req_valid && w_req_taken;
                    r_rsp_target <= (req_valid && w_req_taken) ? r_target[w_req_idx] : '0;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_sweep <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Table storage carries no reset; valid bits are cleared by the init sweep instead.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (r_state == ST_INIT) begin
                r_valid[r_sweep] <= 1'b0;
            end else if (upd_valid) begin
                if (w_upd_hit) begin
                    if (upd_taken) begin
                        r_target[w_upd_idx] <= upd_target;
                        if (r_ctr[w_upd_idx] != '1)
                            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 1'b1;
                    end else if (r_ctr[w_upd_idx] != '0) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 1'b1;
                    end
                end else if (upd_taken) begin
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_ctr[w_upd_idx]    <= w_ctr_init;
                    r_target[w_upd_idx] <= upd_target;
                end
            end
        end
    end

    assign ready      = r_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_taken  = r_rsp_taken;
    assign rsp_target = r_rsp_target;

endmodule

// File: tb/tb_m_branch_predictor.sv
// Directed bench for m_branch_predictor (IDX_W=4): init sweep, counter behaviour, collisions,
// same-cycle lookup/update ordering, reset restart and clock-enable gating.
module tb_m_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        ready;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_taken;
    logic [31:0] rsp_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    int n_total = 0;
    int n_bad   = 0;

    m_branch_predictor #(.IDX_W(4), .TAG_W(8), .CTR_W(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .ready      (ready),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .rsp_valid  (rsp_valid),
        .rsp_taken  (rsp_taken),
        .rsp_target (rsp_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic t, input logic [31:0] tgt);
        chk({tag, ".valid"},  {31'd0, rsp_valid}, {31'd0, v});
        chk({tag, ".taken"},  {31'd0, rsp_taken}, {31'd0, t});
        chk({tag, ".target"}, rsp_target, tgt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given request/update inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt);
        req_valid  = rv;
        req_pc     = rpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        step();
    endtask

    initial begin
        // Reset state and init sweep length
        step();
        step();
        chk("rst.ready", {31'd0, ready}, 32'd0);
        chk_rsp("rst", 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
            chk($sformatf("init.ready%0d", k), {31'd0, ready}, {31'd0, (k == 16)});
            chk($sformatf("init.rspv%0d", k), {31'd0, rsp_valid}, 32'd0);
        end
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("init.upd_dropped", 1'b1, 1'b0, 32'h0);

        // Allocate, hit, same index different tag
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100);
        chk("idle.rspv", {31'd0, rsp_valid}, 32'd0);
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("hit40", 1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h440, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("miss440", 1'b1, 1'b0, 32'h0);

        // Counter walk 2->1->0->0, then up to 3 and saturate
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        chk_rsp("nt1", 1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        chk_rsp("nt2", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        chk_rsp("nt3", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("ctr0", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        chk_rsp("t1", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        chk_rsp("t2", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100);
        chk_rsp("t3", 1'b1, 1'b1, 32'h100);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h180);
        chk_rsp("t4", 1'b1, 1'b1, 32'h100);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("sat3", 1'b1, 1'b1, 32'h180);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("ctr1", 1'b1, 1'b0, 32'h0);

        // Same-cycle lookup and allocation at 0x80 (evicts 0x40 at index 0)
        cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h300);
        chk_rsp("same80", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("after80", 1'b1, 1'b1, 32'h300);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
        cyc(1'b1, 32'h83, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("missnt_keep", 1'b1, 1'b1, 32'h300);
        cyc(1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 32'h444);
        chk_rsp("evicted40", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("hit44", 1'b1, 1'b1, 32'h444);

        // Mid-RUN reset: asynchronous clear, full sweep, everything invalid
        rst = 1'b1;
        #2;
        chk("arst.ready", {31'd0, ready}, 32'd0);
        chk_rsp("arst", 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("rerun.ready%0d", k), {31'd0, ready}, {31'd0, (k == 16)});
            chk($sformatf("rerun.rspv%0d", k), {31'd0, rsp_valid}, 32'd0);
        end
        cyc(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("clr44", 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("clr80", 1'b1, 1'b0, 32'h0);

        // ce gating during INIT stretches the sweep by 5 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            ce = !(k >= 4 && k <= 8);
            cyc(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("ce.ready%0d", k), {31'd0, ready}, {31'd0, (k == 21)});
        end
        ce = 1'b1;
        cyc(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("ce.run80", 1'b1, 1'b0, 32'h0);
        ce = 1'b0;
        cyc(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500);
        chk_rsp("ce.hold", 1'b1, 1'b0, 32'h0);
        chk("ce.hold_ready", {31'd0, ready}, 32'd1);
        ce = 1'b1;
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("ce.upd_ignored", 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h500);
        cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_rsp("ce.upd_ok", 1'b1, 1'b1, 32'h500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
